// File: rtl/mem_stage.sv
// mem_stage: MIPS32 memory-access stage with the MEM/WB pipeline register.
// Runs big-endian loads/stores over a req/ack data bus, stalls the pipeline
// while an access is outstanding, and registers the writeback triple.
module mem_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  mem_wd,
  input  logic        mem_wreg,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_op,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_sdata,
  input  logic        flush,
  output logic        stallreq,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [3:0]  dbus_sel,
  output logic [31:0] dbus_addr,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata,
  output logic [4:0]  wb_wd,
  output logic        wb_wreg,
  output logic [31:0] wb_wdata,
  output logic        misalign,
  output logic        bus_err
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  op_q, op_d;
  logic [4:0]  wd_q, wd_d;
  logic        wreg_q, wreg_d;
  logic [1:0]  off_q, off_d;
  logic        discard_q, discard_d;
  logic        dbus_req_q, dbus_req_d;
  logic        dbus_we_q, dbus_we_d;
  logic [3:0]  dbus_sel_q, dbus_sel_d;
  logic [31:0] dbus_addr_q, dbus_addr_d;
  logic [31:0] dbus_wdata_q, dbus_wdata_d;
  logic [4:0]  wb_wd_q, wb_wd_d;
  logic        wb_wreg_q, wb_wreg_d;
  logic [31:0] wb_wdata_q, wb_wdata_d;
  logic        misalign_q, misalign_d;
  logic        bus_err_q, bus_err_d;
  logic        stall_c;

  logic        is_load, is_store, is_byte, is_half, is_mem, aligned;
  logic [3:0]  sel_new;
  logic [31:0] wdata_new;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_data;

  // Decode the incoming op: access size, alignment, byte lanes and replicated store data
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    is_byte  = 1'b0;
    is_half  = 1'b0;
    case (mem_op)
      OP_LB, OP_LBU: begin is_load = 1'b1;  is_byte = 1'b1; end
      OP_LH, OP_LHU: begin is_load = 1'b1;  is_half = 1'b1; end
      OP_LW:         begin is_load = 1'b1; end
      OP_SB:         begin is_store = 1'b1; is_byte = 1'b1; end
      OP_SH:         begin is_store = 1'b1; is_half = 1'b1; end
      OP_SW:         begin is_store = 1'b1; end
      default:       ;
    endcase
    is_mem  = is_load | is_store;
    aligned = is_byte ? 1'b1 : (is_half ? ~mem_addr[0] : (mem_addr[1:0] == 2'b00));
    if (is_byte)
      sel_new = 4'b1000 >> mem_addr[1:0];
    else if (is_half)
      sel_new = mem_addr[1] ? 4'b0011 : 4'b1100;
    else
      sel_new = 4'b1111;
    if (is_byte)
      wdata_new = {4{mem_sdata[7:0]}};
    else if (is_half)
      wdata_new = {2{mem_sdata[15:0]}};
    else
      wdata_new = mem_sdata;
  end

  // Pick the addressed byte/halfword from the big-endian read word and extend it
  always_comb begin
    case (off_q)
      2'd0:    byte_v = dbus_rdata[31:24];
      2'd1:    byte_v = dbus_rdata[23:16];
      2'd2:    byte_v = dbus_rdata[15:8];
      default: byte_v = dbus_rdata[7:0];
    endcase
    half_v = off_q[1] ? dbus_rdata[15:0] : dbus_rdata[31:16];
    case (op_q)
      OP_LB:   load_data = {{24{byte_v[7]}}, byte_v};
      OP_LBU:  load_data = {24'h000000, byte_v};
      OP_LH:   load_data = {{16{half_v[15]}}, half_v};
      OP_LHU:  load_data = {16'h0000, half_v};
      default: load_data = dbus_rdata;
    endcase
  end

  // Next-state logic: issue accesses from IDLE, wait for ack or timeout in BUSY
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    wd_d         = wd_q;
    wreg_d       = wreg_q;
    off_d        = off_q;
    discard_d    = discard_q;
    dbus_req_d   = dbus_req_q;
    dbus_we_d    = dbus_we_q;
    dbus_sel_d   = dbus_sel_q;
    dbus_addr_d  = dbus_addr_q;
    dbus_wdata_d = dbus_wdata_q;
    wb_wd_d      = wb_wd_q;
    wb_wreg_d    = wb_wreg_q;
    wb_wdata_d   = wb_wdata_q;
    misalign_d   = 1'b0;
    bus_err_d    = 1'b0;
    stall_c      = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush || !is_mem) begin
          wb_wd_d    = mem_wd;
          wb_wreg_d  = mem_wreg & ~flush;
          wb_wdata_d = mem_wdata;
        end else if (!aligned) begin
          wb_wreg_d  = 1'b0;
          misalign_d = 1'b1;
        end else begin
          stall_c      = 1'b1;
          state_d      = BUSY;
          op_d         = mem_op;
          wd_d         = mem_wd;
          wreg_d       = mem_wreg;
          off_d        = mem_addr[1:0];
          discard_d    = 1'b0;
          cnt_d        = 8'd0;
          dbus_req_d   = 1'b1;
          dbus_we_d    = is_store;
          dbus_sel_d   = sel_new;
          dbus_addr_d  = {mem_addr[31:2], 2'b00};
          dbus_wdata_d = wdata_new;
          wb_wreg_d    = 1'b0;
        end
      end
      BUSY: begin
        discard_d = discard_q | flush;
        if (dbus_ack) begin
          state_d    = IDLE;
          dbus_req_d = 1'b0;
          discard_d  = 1'b0;
          if (!dbus_we_q) begin
            wb_wd_d    = wd_q;
            wb_wreg_d  = wreg_q & ~(discard_q | flush);
            wb_wdata_d = load_data;
          end else begin
            wb_wreg_d  = 1'b0;
          end
        end else begin
          stall_c = 1'b1;
          if (cnt_q == TIMEOUT_CNT) begin
            state_d    = IDLE;
            dbus_req_d = 1'b0;
            discard_d  = 1'b0;
            bus_err_d  = 1'b1;
            wb_wreg_d  = 1'b0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, bus and MEM/WB registers; reset clears everything immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= 8'd0;
      op_q         <= 4'd0;
      wd_q         <= 5'd0;
      wreg_q       <= 1'b0;
      off_q        <= 2'd0;
      discard_q    <= 1'b0;
      dbus_req_q   <= 1'b0;
      dbus_we_q    <= 1'b0;
      dbus_sel_q   <= 4'd0;
      dbus_addr_q  <= 32'd0;
      dbus_wdata_q <= 32'd0;
      wb_wd_q      <= 5'd0;
      wb_wreg_q    <= 1'b0;
      wb_wdata_q   <= 32'd0;
      misalign_q   <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      wd_q         <= wd_d;
      wreg_q       <= wreg_d;
      off_q        <= off_d;
      discard_q    <= discard_d;
      dbus_req_q   <= dbus_req_d;
      dbus_we_q    <= dbus_we_d;
      dbus_sel_q   <= dbus_sel_d;
      dbus_addr_q  <= dbus_addr_d;
      dbus_wdata_q <= dbus_wdata_d;
      wb_wd_q      <= wb_wd_d;
      wb_wreg_q    <= wb_wreg_d;
      wb_wdata_q   <= wb_wdata_d;
      misalign_q   <= misalign_d;
      bus_err_q    <= bus_err_d;
    end
  end

  // Stall is masked while reset is held so it drops together with dbus_req
  assign stallreq   = rst & stall_c;
  assign dbus_req   = dbus_req_q;
  assign dbus_we    = dbus_we_q;
  assign dbus_sel   = dbus_sel_q;
  assign dbus_addr  = dbus_addr_q;
  assign dbus_wdata = dbus_wdata_q;
  assign wb_wd      = wb_wd_q;
  assign wb_wreg    = wb_wreg_q;
  assign wb_wdata   = wb_wdata_q;
  assign misalign   = misalign_q;
  assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed bench for mem_stage with a writeback scoreboard.
module tb_mem_stage;

  logic        clk, rst;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_op;
  logic [31:0] mem_addr;
  logic [31:0] mem_sdata;
  logic        mem_flush;
  logic        stallreq, dbus_req, dbus_we;
  logic [3:0]  dbus_sel;
  logic [31:0] dbus_addr, dbus_wdata;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic        misalign, bus_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    bit          checkData;
  } wbExp_t;
  wbExp_t sbQ[$];

  mem_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_op(mem_op), .mem_addr(mem_addr), .mem_sdata(mem_sdata),
    .flush(mem_flush), .stallreq(stallreq),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_sel(dbus_sel),
    .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata),
    .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata),
    .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .misalign(misalign), .bus_err(bus_err)
  );

  // Free-running 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something never returns
  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic [4:0] wd, input logic wreg,
                               input logic [31:0] wdata, input logic [31:0] addr,
                               input logic [31:0] sdata, input logic fl);
    mem_op    = op;
    mem_wd    = wd;
    mem_wreg  = wreg;
    mem_wdata = wdata;
    mem_addr  = addr;
    mem_sdata = sdata;
    mem_flush = fl;
  endtask

  task automatic applyIdle();
    applyStimulus(4'd0, 5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pushExp(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                         input bit checkData);
    wbExp_t e;
    e.wd = wd; e.wreg = wreg; e.wdata = wdata; e.checkData = checkData;
    sbQ.push_back(e);
  endtask

  task automatic popCheck(input string tag);
    wbExp_t e;
    if (sbQ.size() == 0) begin
      checkOutput({tag, "SbEmpty"}, 32'd0, 32'd1);
    end else begin
      e = sbQ.pop_front();
      checkOutput({tag, "Wreg"}, wb_wreg, e.wreg);
      if (e.checkData) begin
        checkOutput({tag, "Wd"}, wb_wd, e.wd);
        checkOutput({tag, "Wdata"}, wb_wdata, e.wdata);
      end
    end
  endtask

  // Issue one aligned memory op, ack it after ackDelay BUSY cycles, then check bus and writeback
  task automatic memAccess(input string tag, input logic [3:0] op, input logic [4:0] wd,
                           input logic [31:0] addr, input logic [31:0] sdata, input int ackDelay,
                           input logic [31:0] rdata, input logic [31:0] expAddr,
                           input logic [3:0] expSel, input logic expWe,
                           input logic [31:0] expBusData, input logic [31:0] expResult);
    int stallCnt = 0;
    applyStimulus(op, wd, 1'b1, 32'hDEAD0000, addr, sdata, 1'b0);
    if (expWe) pushExp(wd, 1'b0, 32'd0, 1'b0);
    else       pushExp(wd, 1'b1, expResult, 1'b1);
    #1;
    if (stallreq) stallCnt++;
    step();
    checkOutput({tag, "Req"}, dbus_req, 1'b1);
    checkOutput({tag, "Addr"}, dbus_addr, expAddr);
    checkOutput({tag, "Sel"}, dbus_sel, expSel);
    checkOutput({tag, "We"}, dbus_we, expWe);
    if (expWe) checkOutput({tag, "BusWdata"}, dbus_wdata, expBusData);
    checkOutput({tag, "Bubble"}, wb_wreg, 1'b0);
    for (int i = 0; i < ackDelay; i++) begin
      dbus_rdata = $urandom;
      if (stallreq) stallCnt++;
      step();
    end
    dbus_ack   = 1'b1;
    dbus_rdata = rdata;
    #1;
    checkOutput({tag, "AckStall"}, stallreq, 1'b0);
    step();
    dbus_ack = 1'b0;
    checkOutput({tag, "StallCycles"}, stallCnt, ackDelay + 1);
    checkOutput({tag, "ReqDrop"}, dbus_req, 1'b0);
    popCheck(tag);
    applyIdle();
  endtask

  // Directed sequence
  initial begin
    int reqCnt;
    int errEarly;
    rst        = 1'b0;
    dbus_ack   = 1'b0;
    dbus_rdata = 32'd0;
    applyIdle();
    #2;
    checkOutput("rstStall", stallreq, 1'b0);
    checkOutput("rstReq", dbus_req, 1'b0);
    checkOutput("rstWreg", wb_wreg, 1'b0);
    checkOutput("rstWdata", wb_wdata, 32'd0);
    checkOutput("rstMisalign", misalign, 1'b0);
    checkOutput("rstBusErr", bus_err, 1'b0);
    #10 rst = 1'b1;
    step();

    // ALU passthrough, flushed ALU op, undefined op code, flushed memory op
    applyStimulus(4'd0, 5'd5, 1'b1, 32'h1234, 32'd0, 32'd0, 1'b0);
    pushExp(5'd5, 1'b1, 32'h1234, 1'b1);
    #1 checkOutput("aluStall", stallreq, 1'b0);
    step();
    popCheck("alu");
    applyStimulus(4'd0, 5'd7, 1'b1, 32'h55, 32'd0, 32'd0, 1'b1);
    pushExp(5'd7, 1'b0, 32'h55, 1'b1);
    step();
    popCheck("aluFlush");
    applyStimulus(4'd12, 5'd9, 1'b1, 32'hCAFE, 32'h101, 32'd0, 1'b0);
    pushExp(5'd9, 1'b1, 32'hCAFE, 1'b1);
    #1 checkOutput("op12Stall", stallreq, 1'b0);
    step();
    checkOutput("op12Req", dbus_req, 1'b0);
    popCheck("op12");
    applyStimulus(4'd5, 5'd10, 1'b1, 32'h77, 32'h100, 32'd0, 1'b1);
    pushExp(5'd10, 1'b0, 32'h77, 1'b1);
    #1 checkOutput("lwFlushStall", stallreq, 1'b0);
    step();
    checkOutput("lwFlushReq", dbus_req, 1'b0);
    popCheck("lwFlush");

    // Loads and stores across lanes and extensions
    memAccess("lb",  4'd1, 5'd3,  32'h101, 32'd0, 3, 32'h11F23344, 32'h100, 4'b0100, 1'b0, 32'd0, 32'hFFFFFFF2);
    memAccess("lbu", 4'd2, 5'd4,  32'h101, 32'd0, 3, 32'h11F23344, 32'h100, 4'b0100, 1'b0, 32'd0, 32'h000000F2);
    memAccess("lb3", 4'd1, 5'd6,  32'h107, 32'd0, 1, 32'h00000080, 32'h104, 4'b0001, 1'b0, 32'd0, 32'hFFFFFF80);
    memAccess("lh",  4'd3, 5'd14, 32'h102, 32'd0, 0, 32'h12348765, 32'h100, 4'b0011, 1'b0, 32'd0, 32'hFFFF8765);
    memAccess("lhu", 4'd4, 5'd15, 32'h200, 32'd0, 1, 32'h87651234, 32'h200, 4'b1100, 1'b0, 32'd0, 32'h00008765);
    memAccess("lw",  4'd5, 5'd16, 32'h104, 32'd0, 2, 32'hDEADBEEF, 32'h104, 4'b1111, 1'b0, 32'd0, 32'hDEADBEEF);
    memAccess("sh",  4'd7, 5'd17, 32'h202, 32'hABCD, 1, 32'd0, 32'h200, 4'b0011, 1'b1, 32'hABCDABCD, 32'd0);
    memAccess("sb",  4'd6, 5'd18, 32'h003, 32'h12345678, 0, 32'd0, 32'h000, 4'b0001, 1'b1, 32'h78787878, 32'd0);
    memAccess("sw",  4'd8, 5'd19, 32'h010, 32'hCAFEBABE, 2, 32'd0, 32'h010, 4'b1111, 1'b1, 32'hCAFEBABE, 32'd0);

    // Misaligned word load after a writing ALU op
    applyStimulus(4'd0, 5'd1, 1'b1, 32'hA5, 32'd0, 32'd0, 1'b0);
    pushExp(5'd1, 1'b1, 32'hA5, 1'b1);
    step();
    popCheck("preMis");
    applyStimulus(4'd5, 5'd12, 1'b1, 32'd0, 32'h103, 32'd0, 1'b0);
    pushExp(5'd12, 1'b0, 32'd0, 1'b0);
    #1 checkOutput("misStall", stallreq, 1'b0);
    step();
    checkOutput("misPulse", misalign, 1'b1);
    checkOutput("misNoBusErr", bus_err, 1'b0);
    checkOutput("misReq", dbus_req, 1'b0);
    popCheck("mis");
    applyIdle();
    step();
    checkOutput("misPulseEnd", misalign, 1'b0);
    checkOutput("misReqAfter", dbus_req, 1'b0);

    // Misaligned halfword store
    applyStimulus(4'd7, 5'd2, 1'b0, 32'd0, 32'h201, 32'h1111, 1'b0);
    #1 checkOutput("misShStall", stallreq, 1'b0);
    step();
    checkOutput("misShPulse", misalign, 1'b1);
    checkOutput("misShReq", dbus_req, 1'b0);
    applyIdle();
    step();

    // Flush while BUSY, then ack: result suppressed
    applyStimulus(4'd5, 5'd8, 1'b1, 32'd0, 32'h400, 32'd0, 1'b0);
    pushExp(5'd8, 1'b0, 32'd0, 1'b0);
    step();
    checkOutput("flushReq", dbus_req, 1'b1);
    mem_flush = 1'b1;
    step();
    mem_flush = 1'b0;
    checkOutput("flushReqHeld", dbus_req, 1'b1);
    step();
    dbus_ack   = 1'b1;
    dbus_rdata = 32'h13572468;
    #1 checkOutput("flushAckStall", stallreq, 1'b0);
    step();
    dbus_ack = 1'b0;
    popCheck("flushBusy");
    checkOutput("flushReqDrop", dbus_req, 1'b0);
    applyIdle();
    memAccess("postFlush", 4'd5, 5'd20, 32'h408, 32'd0, 0, 32'h0BADF00D, 32'h408, 4'b1111, 1'b0, 32'd0, 32'h0BADF00D);

    // Timeout: no ack ever arrives
    applyStimulus(4'd5, 5'd11, 1'b1, 32'd0, 32'h300, 32'd0, 1'b0);
    pushExp(5'd11, 1'b0, 32'd0, 1'b0);
    step();
    reqCnt   = 0;
    errEarly = 0;
    for (int i = 0; i < 20 && dbus_req; i++) begin
      reqCnt++;
      if (bus_err) errEarly++;
      step();
    end
    checkOutput("toReqCycles", reqCnt, 5);
    checkOutput("toErrEarly", errEarly, 0);
    checkOutput("toBusErr", bus_err, 1'b1);
    checkOutput("toNoMisalign", misalign, 1'b0);
    popCheck("timeout");
    applyIdle();
    #1 checkOutput("toStall", stallreq, 1'b0);
    step();
    checkOutput("toBusErrEnd", bus_err, 1'b0);

    // Ack while IDLE is ignored
    applyStimulus(4'd0, 5'd2, 1'b1, 32'h99, 32'd0, 32'd0, 1'b0);
    dbus_ack   = 1'b1;
    dbus_rdata = 32'hFFFFFFFF;
    step();
    dbus_ack = 1'b0;
    checkOutput("idleAckWdata", wb_wdata, 32'h99);
    checkOutput("idleAckReq", dbus_req, 1'b0);

    // Reset asserted mid-BUSY
    applyStimulus(4'd5, 5'd13, 1'b1, 32'd0, 32'h500, 32'd0, 1'b0);
    step();
    checkOutput("rstBusyReq", dbus_req, 1'b1);
    #2 rst = 1'b0;
    #1;
    checkOutput("rstBusyReqDrop", dbus_req, 1'b0);
    checkOutput("rstBusyStall", stallreq, 1'b0);
    checkOutput("rstBusyWreg", wb_wreg, 1'b0);
    applyIdle();
    step();
    rst = 1'b1;
    step();
    checkOutput("postRstReq", dbus_req, 1'b0);

    checkOutput("sbDrain", sbQ.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
